// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared RV32I pipeline control encoding
// Purpose: packed control word layout, write-back select and ALU op codes,
//   and the all-zero bubble control word used by the pipeline registers.
// Ports: none (package).
package rv_pipe_pkg;

  localparam int ALUOP_W = 4;
  localparam int CTRL_W  = 8 + ALUOP_W;

  // Control word, MSB first: regWEn, memRead, memWrite, branch, jump,
  // aluSrc, wbSel[1:0], aluOp[ALUOP_W-1:0].
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int CTRL_WBSEL_LSB = ALUOP_W;
  localparam int CTRL_ALUSRC    = ALUOP_W + 2;
  localparam int CTRL_JUMP      = ALUOP_W + 3;
  localparam int CTRL_BRANCH    = ALUOP_W + 4;
  localparam int CTRL_MEMWRITE  = ALUOP_W + 5;
  localparam int CTRL_MEMREAD   = ALUOP_W + 6;
  localparam int CTRL_REGWEN    = ALUOP_W + 7;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;
  localparam logic [1:0] WBSEL_IMM = 2'd3;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 4'd9;

  // A bubble must never write a register, store, or redirect the PC.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
// Purpose: flags when the instruction in ID reads the destination of a
//   load currently in EX, so the front end must stall one cycle.
// Ports:
//   ex_valid, ex_mem_read, ex_rd       EX-stage (ID/EX register) load info
//   id_valid, id_use_rs1, id_use_rs2   ID instruction validity and source usage
//   id_rs1, id_rs2                     ID source register indices
//   hazard                             stall request
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);
  import rv_pipe_pkg::*;

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never needs a stall.
  assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                  (rs1_hit || rs2_hit) && id_valid;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use stall control
// Purpose: registers decoded ID fields for EX, inserts bubbles on flush,
//   load-use hazard or invalid ID, freezes on memory hold, drives the
//   PC / IF-ID write enables and counts load-use bubbles.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   id_*                               decoded ID-stage instruction fields
//   ex_flush                           taken branch/jump in EX, squash ID
//   mem_hold                           data-memory stall, freeze front end
//   IdEx_*                             registered fields presented to EX
//   pc_wEn, IfId_wEn                   front-end write enables
//   loadUseCnt                         load-use bubbles since reset (wraps)
module id_ex_hazard_reg
  import rv_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = rv_pipe_pkg::ALUOP_W,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1Data,
  input  logic [XLEN-1:0]      id_rs2Data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [4:0]           id_regRs1,
  input  logic [4:0]           id_regRs2,
  input  logic [4:0]           id_regRd,
  input  logic                 id_useRs1,
  input  logic                 id_useRs2,
  input  logic [ALUOP_W+7:0]   id_ctrl,
  input  logic                 ex_flush,
  input  logic                 mem_hold,
  output logic                 IdEx_valid,
  output logic [XLEN-1:0]      IdEx_pc,
  output logic [XLEN-1:0]      IdEx_rs1Data,
  output logic [XLEN-1:0]      IdEx_rs2Data,
  output logic [XLEN-1:0]      IdEx_imm,
  output logic [4:0]           IdEx_regRs1,
  output logic [4:0]           IdEx_regRs2,
  output logic [4:0]           IdEx_regRd,
  output logic [ALUOP_W+7:0]   IdEx_ctrl,
  output logic                 pc_wEn,
  output logic                 IfId_wEn,
  output logic [CNT_W-1:0]     loadUseCnt
);

  localparam int CW = ALUOP_W + 8;

  logic hazard;
  logic front_wen;

  load_use_detect u_load_use_detect (
    .ex_valid    (IdEx_valid),
    .ex_mem_read (IdEx_ctrl[CW-2]),
    .ex_rd       (IdEx_regRd),
    .id_valid    (id_valid),
    .id_use_rs1  (id_useRs1),
    .id_use_rs2  (id_useRs2),
    .id_rs1      (id_regRs1),
    .id_rs2      (id_regRs2),
    .hazard      (hazard)
  );

  // Flush redirects the PC, so it must override a stall. Reset also
  // releases the front end since the zeroed register cannot hold a load.
  assign front_wen = !mem_hold && (!rst_n || ex_flush || !hazard);
  assign pc_wEn    = front_wen;
  assign IfId_wEn  = front_wen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      IdEx_valid   <= 1'b0;
      IdEx_pc      <= '0;
      IdEx_rs1Data <= '0;
      IdEx_rs2Data <= '0;
      IdEx_imm     <= '0;
      IdEx_regRs1  <= '0;
      IdEx_regRs2  <= '0;
      IdEx_regRd   <= '0;
      IdEx_ctrl    <= '0;
      loadUseCnt   <= '0;
    end else if (mem_hold) begin
      // Whole front pipeline frozen: every register keeps its value.
    end else if (ex_flush || hazard) begin
      IdEx_valid   <= 1'b0;
      IdEx_pc      <= '0;
      IdEx_rs1Data <= '0;
      IdEx_rs2Data <= '0;
      IdEx_imm     <= '0;
      IdEx_regRs1  <= '0;
      IdEx_regRs2  <= '0;
      IdEx_regRd   <= '0;
      IdEx_ctrl    <= '0;
      if (!ex_flush) begin
        loadUseCnt <= loadUseCnt + CNT_W'(1);
      end
    end else begin
      IdEx_valid   <= id_valid;
      IdEx_pc      <= id_pc;
      IdEx_rs1Data <= id_rs1Data;
      IdEx_rs2Data <= id_rs2Data;
      IdEx_imm     <= id_imm;
      IdEx_regRs1  <= id_regRs1;
      IdEx_regRs2  <= id_regRs2;
      IdEx_regRd   <= id_regRd;
      IdEx_ctrl    <= id_valid ? id_ctrl : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb/tb_id_ex_hazard_reg.sv - directed self-checking bench for id_ex_hazard_reg
module tb_id_ex_hazard_reg;
  import rv_pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  // lw: regWEn, memRead, aluSrc, wbSel=MEM, aluOp=ADD
  localparam logic [11:0] C_LW  = 12'hC50;
  // add: regWEn, wbSel=ALU, aluOp=ADD
  localparam logic [11:0] C_ADD = 12'h800;
  // sw: memWrite, aluSrc
  localparam logic [11:0] C_SW  = 12'h240;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rs1Data, id_rs2Data, id_imm;
  logic [4:0]       id_regRs1, id_regRs2, id_regRd;
  logic             id_useRs1, id_useRs2;
  logic [11:0]      id_ctrl;
  logic             ex_flush, mem_hold;
  logic             IdEx_valid;
  logic [XLEN-1:0]  IdEx_pc, IdEx_rs1Data, IdEx_rs2Data, IdEx_imm;
  logic [4:0]       IdEx_regRs1, IdEx_regRs2, IdEx_regRd;
  logic [11:0]      IdEx_ctrl;
  logic             pc_wEn, IfId_wEn;
  logic [CNT_W-1:0] loadUseCnt;

  int checks = 0;
  int errors = 0;

  id_ex_hazard_reg #(.XLEN(XLEN), .ALUOP_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1Data(id_rs1Data), .id_rs2Data(id_rs2Data), .id_imm(id_imm),
    .id_regRs1(id_regRs1), .id_regRs2(id_regRs2), .id_regRd(id_regRd),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2), .id_ctrl(id_ctrl),
    .ex_flush(ex_flush), .mem_hold(mem_hold), .IdEx_valid(IdEx_valid),
    .IdEx_pc(IdEx_pc), .IdEx_rs1Data(IdEx_rs1Data), .IdEx_rs2Data(IdEx_rs2Data),
    .IdEx_imm(IdEx_imm), .IdEx_regRs1(IdEx_regRs1), .IdEx_regRs2(IdEx_regRs2),
    .IdEx_regRd(IdEx_regRd), .IdEx_ctrl(IdEx_ctrl), .pc_wEn(pc_wEn),
    .IfId_wEn(IfId_wEn), .loadUseCnt(loadUseCnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [11:0] ctrl);
    id_valid   = v;
    id_pc      = pc;
    id_rs1Data = pc ^ 32'hAAAA_0000;
    id_rs2Data = pc ^ 32'h0000_5555;
    id_imm     = pc + 32'd4;
    id_regRs1  = rs1;
    id_regRs2  = rs2;
    id_regRd   = rd;
    id_useRs1  = u1;
    id_useRs2  = u2;
    id_ctrl    = ctrl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_flush = 1'b0; mem_hold = 1'b0;
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    step();
    checks++; if (IdEx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", IdEx_valid); end
    checks++; if (IdEx_ctrl !== BUBBLE_CTRL) begin errors++; $display("FAIL reset_ctrl got %h want 000", IdEx_ctrl); end
    checks++; if (IdEx_pc !== 32'h0 || IdEx_regRd !== 5'd0) begin errors++; $display("FAIL reset_fields pc %h rd %0d want 0 0", IdEx_pc, IdEx_regRd); end
    checks++; if (loadUseCnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", loadUseCnt); end
    checks++; if (pc_wEn !== 1'b1 || IfId_wEn !== 1'b1) begin errors++; $display("FAIL reset_wen got %0b%0b want 11", pc_wEn, IfId_wEn); end
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    set_id(1'b1, 32'h100, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    checks++; if (IdEx_valid !== 1'b1 || IdEx_ctrl !== C_LW || IdEx_regRd !== 5'd5 || IdEx_pc !== 32'h100)
      begin errors++; $display("FAIL lu_capture got v%0b ctrl %h rd %0d pc %h want v1 c50 5 100", IdEx_valid, IdEx_ctrl, IdEx_regRd, IdEx_pc); end
    checks++; if (IdEx_rs1Data !== 32'hAAAA_0100 || IdEx_imm !== 32'h104)
      begin errors++; $display("FAIL lu_data got %h %h want aaaa0100 104", IdEx_rs1Data, IdEx_imm); end
    set_id(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD);
    checks++; if (pc_wEn !== 1'b0 || IfId_wEn !== 1'b0) begin errors++; $display("FAIL lu_stall_wen got %0b%0b want 00", pc_wEn, IfId_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b0 || IdEx_ctrl !== 12'h0 || IdEx_regRd !== 5'd0)
      begin errors++; $display("FAIL lu_bubble got v%0b ctrl %h rd %0d want 0 000 0", IdEx_valid, IdEx_ctrl, IdEx_regRd); end
    checks++; if (loadUseCnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", loadUseCnt); end
    checks++; if (pc_wEn !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", pc_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b1 || IdEx_ctrl !== C_ADD || IdEx_regRs1 !== 5'd5 || IdEx_regRd !== 5'd6)
      begin errors++; $display("FAIL lu_resume got v%0b ctrl %h rs1 %0d rd %0d want 1 800 5 6", IdEx_valid, IdEx_ctrl, IdEx_regRs1, IdEx_regRd); end
  endtask

  task automatic test_flush();
    set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b1, 32'h204, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD);
    ex_flush = 1'b1; #1;
    checks++; if (pc_wEn !== 1'b1 || IfId_wEn !== 1'b1) begin errors++; $display("FAIL flush_wen got %0b%0b want 11", pc_wEn, IfId_wEn); end
    step();
    ex_flush = 1'b0;
    checks++; if (IdEx_valid !== 1'b0 || IdEx_ctrl !== 12'h0) begin errors++; $display("FAIL flush_bubble got v%0b ctrl %h want 0 000", IdEx_valid, IdEx_ctrl); end
    checks++; if (loadUseCnt !== 4'd1) begin errors++; $display("FAIL flush_cnt got %0d want 1", loadUseCnt); end
  endtask

  task automatic test_x0();
    set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b1, 32'h304, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, C_ADD);
    checks++; if (pc_wEn !== 1'b1) begin errors++; $display("FAIL x0_wen got %0b want 1", pc_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b1 || IdEx_regRs1 !== 5'd0 || IdEx_regRd !== 5'd6 || IdEx_pc !== 32'h304)
      begin errors++; $display("FAIL x0_capture got v%0b rs1 %0d rd %0d pc %h want 1 0 6 304", IdEx_valid, IdEx_regRs1, IdEx_regRd, IdEx_pc); end
  endtask

  task automatic test_mem_hold();
    set_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b1, 32'h404, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD);
    ex_flush = 1'b1; mem_hold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc_wEn !== 1'b0 || IfId_wEn !== 1'b0) begin errors++; $display("FAIL hold_wen[%0d] got %0b%0b want 00", i, pc_wEn, IfId_wEn); end
      step();
      checks++; if (IdEx_valid !== 1'b1 || IdEx_pc !== 32'h400 || IdEx_ctrl !== C_LW || IdEx_regRd !== 5'd5)
        begin errors++; $display("FAIL hold_regs[%0d] got v%0b pc %h ctrl %h rd %0d want 1 400 c50 5", i, IdEx_valid, IdEx_pc, IdEx_ctrl, IdEx_regRd); end
      checks++; if (loadUseCnt !== 4'd1) begin errors++; $display("FAIL hold_cnt[%0d] got %0d want 1", i, loadUseCnt); end
    end
    ex_flush = 1'b0; mem_hold = 1'b0; #1;
    checks++; if (pc_wEn !== 1'b0) begin errors++; $display("FAIL hold_release_stall got %0b want 0", pc_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b0 || loadUseCnt !== 4'd2) begin errors++; $display("FAIL hold_release_bubble got v%0b cnt %0d want 0 2", IdEx_valid, loadUseCnt); end
  endtask

  task automatic test_rs2_only();
    set_id(1'b1, 32'h500, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b1, 32'h504, 5'd5, 5'd9, 5'd0, 1'b0, 1'b1, C_SW);
    checks++; if (pc_wEn !== 1'b1) begin errors++; $display("FAIL rs1_unused_wen got %0b want 1", pc_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b1 || IdEx_ctrl !== C_SW || loadUseCnt !== 4'd2)
      begin errors++; $display("FAIL rs1_unused_capture got v%0b ctrl %h cnt %0d want 1 240 2", IdEx_valid, IdEx_ctrl, loadUseCnt); end
    set_id(1'b1, 32'h508, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b1, 32'h50C, 5'd3, 5'd5, 5'd0, 1'b0, 1'b1, C_SW);
    checks++; if (pc_wEn !== 1'b0 || IfId_wEn !== 1'b0) begin errors++; $display("FAIL rs2_hit_wen got %0b%0b want 00", pc_wEn, IfId_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b0 || loadUseCnt !== 4'd3) begin errors++; $display("FAIL rs2_hit_bubble got v%0b cnt %0d want 0 3", IdEx_valid, loadUseCnt); end
  endtask

  task automatic test_id_invalid();
    set_id(1'b1, 32'h600, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b0, 32'h604, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, C_ADD);
    checks++; if (pc_wEn !== 1'b1) begin errors++; $display("FAIL invalid_wen got %0b want 1", pc_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b0 || IdEx_ctrl !== 12'h0 || loadUseCnt !== 4'd3)
      begin errors++; $display("FAIL invalid_capture got v%0b ctrl %h cnt %0d want 0 000 3", IdEx_valid, IdEx_ctrl, loadUseCnt); end
  endtask

  task automatic one_hazard();
    set_id(1'b1, 32'h700, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b1, 32'h704, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, C_ADD);
    step();
  endtask

  task automatic test_back_to_back();
    // Count is 3; 12 more reach 15, the 13th wraps to 0. Both sources hit each time.
    for (int i = 0; i < 12; i++) one_hazard();
    checks++; if (loadUseCnt !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d want 15", loadUseCnt); end
    one_hazard();
    checks++; if (loadUseCnt !== 4'd0) begin errors++; $display("FAIL wrap_post got %0d want 0", loadUseCnt); end
    one_hazard();
    checks++; if (loadUseCnt !== 4'd1) begin errors++; $display("FAIL wrap_next got %0d want 1", loadUseCnt); end
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 32'h800, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    set_id(1'b1, 32'h804, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD);
    checks++; if (pc_wEn !== 1'b0) begin errors++; $display("FAIL rst_stall_pre got %0b want 0", pc_wEn); end
    rst_n = 1'b0; #1;
    checks++; if (pc_wEn !== 1'b1 || IfId_wEn !== 1'b1) begin errors++; $display("FAIL rst_stall_wen got %0b%0b want 11", pc_wEn, IfId_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b0 || IdEx_ctrl !== 12'h0 || IdEx_pc !== 32'h0 || IdEx_regRd !== 5'd0 || loadUseCnt !== 4'd0)
      begin errors++; $display("FAIL rst_stall_regs got v%0b ctrl %h pc %h rd %0d cnt %0d want all 0", IdEx_valid, IdEx_ctrl, IdEx_pc, IdEx_regRd, loadUseCnt); end
    rst_n = 1'b1; #1;
    checks++; if (pc_wEn !== 1'b1) begin errors++; $display("FAIL rst_stall_after got %0b want 1", pc_wEn); end
    step();
    checks++; if (IdEx_valid !== 1'b1 || IdEx_pc !== 32'h804 || loadUseCnt !== 4'd0)
      begin errors++; $display("FAIL rst_stall_capture got v%0b pc %h cnt %0d want 1 804 0", IdEx_valid, IdEx_pc, loadUseCnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_x0();
    test_mem_hold();
    test_rs2_only();
    test_id_invalid();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
